// File: rtl/signed_mult_seq.sv
// Sequential 5-bit (WIDTH) two's-complement multiplier: magnitude shift-add plus sign fix-up.
// Optional macro SIGNED_MULT_SEQ_EARLY_EXIT_EN ends CALC once no multiplier bits remain.
module signed_mult_seq #(
  parameter int unsigned WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   Mcand,
  input  logic [WIDTH-1:0]   Mplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic                 sign_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CntW-1:0]      cnt_q;

  logic [WIDTH-1:0]     mcand_abs;
  logic [WIDTH-1:0]     mplier_abs;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 last_step;

  // The most negative operand keeps its bit pattern, which reads as the correct unsigned magnitude.
  always_comb begin
    mcand_abs  = Mcand[WIDTH-1]  ? -Mcand  : Mcand;
    mplier_abs = Mplier[WIDTH-1] ? -Mplier : Mplier;
    partial    = {{WIDTH{1'b0}}, mcand_q} << cnt_q;
    acc_next   = mplier_q[0] ? (acc_q + partial) : acc_q;
  end

`ifdef SIGNED_MULT_SEQ_EARLY_EXIT_EN
  assign last_step = (cnt_q == LastCnt) || ((mplier_q >> 1) == '0);
`else
  assign last_step = (cnt_q == LastCnt);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            mcand_q  <= mcand_abs;
            mplier_q <= mplier_abs;
            sign_q   <= Mcand[WIDTH-1] ^ Mplier[WIDTH-1];
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StCalc;
          end
        end
        StCalc: begin
          acc_q    <= acc_next;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CntW'(1);
          if (last_step) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          // Negating a zero accumulator yields zero, so no special case is needed.
          out     <= sign_q ? -acc_q : acc_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
